// File: rtl/alu_result_buffer_if.sv
// alu_result_buffer_if: bundles the ALU-facing capture signals, the consumer
// valid/ready handshake and the debug status of alu_result_buffer.
//   master : the environment (ALU plus consumer); drives alu_*, out_ready.
//   slave  : the buffer; drives out_*, count, full, empty, drop_cnt, err_cnt.
// Optional macro ALU_RESULT_BUFFER_PARITY_EN adds out_par and par_err.
interface alu_result_buffer_if #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned OP_W   = 3,
  parameter int unsigned CNT_W  = 8
) ();

  logic [OP_W-1:0]              alu_opcode;
  logic                         alu_valid;
  logic [DATA_W-1:0]            alu_result;
  logic                         out_valid;
  logic                         out_ready;
  logic [DATA_W-1:0]            out_data;
  logic [OP_W-1:0]              out_tag;
  logic [$clog2(DEPTH+1)-1:0]   count;
  logic                         full;
  logic                         empty;
  logic [CNT_W-1:0]             drop_cnt;
  logic [CNT_W-1:0]             err_cnt;
`ifdef ALU_RESULT_BUFFER_PARITY_EN
  logic                         out_par;
  logic                         par_err;
`endif

  modport master (
    output alu_opcode, alu_valid, alu_result, out_ready,
    input  out_valid, out_data, out_tag, count, full, empty, drop_cnt, err_cnt
`ifdef ALU_RESULT_BUFFER_PARITY_EN
    , input out_par, par_err
`endif
  );

  modport slave (
    input  alu_opcode, alu_valid, alu_result, out_ready,
    output out_valid, out_data, out_tag, count, full, empty, drop_cnt, err_cnt
`ifdef ALU_RESULT_BUFFER_PARITY_EN
    , output out_par, par_err
`endif
  );

endinterface

// File: rtl/alu_result_buffer.sv
// alu_result_buffer: captures registered ALU results, tags each with the opcode
// that produced it (the opcode seen one cycle earlier), queues them in a
// first-word-fall-through FIFO and drains them over a valid/ready handshake.
// Saturating debug counters record results dropped on overflow and
// invalid-opcode cycles.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous reset, active low
//   bus  - alu_result_buffer_if.slave (ALU capture, consumer handshake, status)
// Optional macro ALU_RESULT_BUFFER_PARITY_EN: stores an even-parity bit per
// entry and exposes out_par / par_err.
module alu_result_buffer #(
  parameter int unsigned DEPTH  = 4,  // power of two, >= 2
  parameter int unsigned DATA_W = 16,
  parameter int unsigned OP_W   = 3,
  parameter int unsigned CNT_W  = 8
) (
  input logic                clk,
  input logic                rst,
  alu_result_buffer_if.slave bus
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CountW = $clog2(DEPTH + 1);
`ifdef ALU_RESULT_BUFFER_PARITY_EN
  localparam int unsigned EntryW = 1 + OP_W + DATA_W;
`else
  localparam int unsigned EntryW = OP_W + DATA_W;
`endif
  localparam logic [OP_W-1:0]   OpMaxLegal = OP_W'(5);
  localparam logic [CountW-1:0] CountFull  = CountW'(DEPTH);

  logic [OP_W-1:0]   op_q, op_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0] count_q, count_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [EntryW-1:0] mem_q [DEPTH];

  logic              full, empty, push, pop;
  logic [EntryW-1:0] wr_entry;
  logic [EntryW-1:0] head;

  always_comb begin
    full  = (count_q == CountFull);
    empty = (count_q == '0);
    pop   = !empty && bus.out_ready;
    // A full FIFO still accepts a result when the head leaves in the same cycle.
    push  = bus.alu_valid && (!full || pop);

    op_d = bus.alu_opcode;

    // Pointers wrap naturally because DEPTH is a power of two.
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CountW'(1);
      2'b01:   count_d = count_q - CountW'(1);
      default: count_d = count_q;
    endcase

    drop_cnt_d = drop_cnt_q;
    if (bus.alu_valid && !push && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end

    // The ALU flags an illegal opcode by presenting 16'hDEAD with valid low.
    err_cnt_d = err_cnt_q;
    if (!bus.alu_valid && (op_q > OpMaxLegal) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end

`ifdef ALU_RESULT_BUFFER_PARITY_EN
    wr_entry = {^bus.alu_result, op_q, bus.alu_result};
`else
    wr_entry = {op_q, bus.alu_result};
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      op_q       <= op_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Storage needs no reset: empty masks the head to zero.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  assign head = mem_q[rd_ptr_q];

  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? '0 : head[DATA_W-1:0];
  assign bus.out_tag   = empty ? '0 : head[DATA_W +: OP_W];
  assign bus.count     = count_q;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.drop_cnt  = drop_cnt_q;
  assign bus.err_cnt   = err_cnt_q;

`ifdef ALU_RESULT_BUFFER_PARITY_EN
  logic par_err_q, par_err_d;

  always_comb begin
    // Recompute parity of the departing word and compare with the stored bit.
    par_err_d = pop && ((^head[DATA_W-1:0]) != head[EntryW-1]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  assign bus.out_par = empty ? 1'b0 : head[EntryW-1];
  assign bus.par_err = par_err_q;
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed, table-driven bench for alu_result_buffer (DEPTH=4). Each table row
// is one clock: inputs driven at the falling edge, state checked 1ns after the
// following rising edge. Hand-written sequences cover counter saturation and,
// when ALU_RESULT_BUFFER_PARITY_EN is defined, the parity outputs.
module tb_alu_result_buffer;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned NVec   = 27;

  logic clk;
  logic rst;

  alu_result_buffer_if #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .OP_W  (OP_W),
    .CNT_W (CNT_W)
  ) bus ();

  alu_result_buffer #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .OP_W  (OP_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [2:0]  op;
    logic        v;
    logic [15:0] res;
    logic        rdy;
    logic        e_valid;
    logic [15:0] e_data;
    logic [2:0]  e_tag;
    logic [2:0]  e_count;
    logic        e_full;
    logic        e_empty;
    logic [7:0]  e_drop;
    logic [7:0]  e_err;
  } vec_t;

  vec_t vecs [NVec];
  int checks;
  int failures;

  function automatic vec_t mk(input logic r, input logic [2:0] op, input logic v,
                              input logic [15:0] res, input logic rdy,
                              input logic ev, input logic [15:0] ed,
                              input logic [2:0] et, input logic [2:0] ec,
                              input logic ef, input logic ee,
                              input logic [7:0] edrop, input logic [7:0] eerr);
    vec_t t;
    t.rst = r; t.op = op; t.v = v; t.res = res; t.rdy = rdy;
    t.e_valid = ev; t.e_data = ed; t.e_tag = et; t.e_count = ec;
    t.e_full = ef; t.e_empty = ee; t.e_drop = edrop; t.e_err = eerr;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [2:0] op, input logic v,
                       input logic [15:0] res, input logic rdy);
    @(negedge clk);
    rst            = r;
    bus.alu_opcode = op;
    bus.alu_valid  = v;
    bus.alu_result = res;
    bus.out_ready  = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst            = 1'b0;
    bus.alu_opcode = '0;
    bus.alu_valid  = 1'b0;
    bus.alu_result = '0;
    bus.out_ready  = 1'b0;

    //              rst op v  res       rdy  val data      tag cnt f  e  drop err
    // Reset, then one add (10+15=25) tagged with opcode 000.
    vecs[0]  = mk(0, 0, 0, 16'h0000, 0,   0, 16'h0000, 0, 0, 0, 1, 0, 0);
    vecs[1]  = mk(0, 0, 0, 16'h0000, 0,   0, 16'h0000, 0, 0, 0, 1, 0, 0);
    vecs[2]  = mk(1, 0, 0, 16'h0000, 1,   0, 16'h0000, 0, 0, 0, 1, 0, 0);
    vecs[3]  = mk(1, 0, 1, 16'd25,   1,   1, 16'd25,   0, 1, 0, 0, 0, 0);
    vecs[4]  = mk(1, 0, 0, 16'h0000, 1,   0, 16'h0000, 0, 0, 0, 1, 0, 0);
    // Fill with 1..4 (tags 1..4), fifth result dropped.
    vecs[5]  = mk(1, 1, 0, 16'h0000, 0,   0, 16'h0000, 0, 0, 0, 1, 0, 0);
    vecs[6]  = mk(1, 2, 1, 16'd1,    0,   1, 16'd1,    1, 1, 0, 0, 0, 0);
    vecs[7]  = mk(1, 3, 1, 16'd2,    0,   1, 16'd1,    1, 2, 0, 0, 0, 0);
    vecs[8]  = mk(1, 4, 1, 16'd3,    0,   1, 16'd1,    1, 3, 0, 0, 0, 0);
    vecs[9]  = mk(1, 5, 1, 16'd4,    0,   1, 16'd1,    1, 4, 1, 0, 0, 0);
    vecs[10] = mk(1, 0, 1, 16'd5,    0,   1, 16'd1,    1, 4, 1, 0, 1, 0);
    // Push and pop together while full, then drain: 2,3,4,AA.
    vecs[11] = mk(1, 0, 1, 16'h00AA, 1,   1, 16'd2,    2, 4, 1, 0, 1, 0);
    vecs[12] = mk(1, 0, 0, 16'h0000, 1,   1, 16'd3,    3, 3, 0, 0, 1, 0);
    vecs[13] = mk(1, 0, 0, 16'h0000, 1,   1, 16'd4,    4, 2, 0, 0, 1, 0);
    vecs[14] = mk(1, 0, 0, 16'h0000, 1,   1, 16'h00AA, 0, 1, 0, 0, 1, 0);
    vecs[15] = mk(1, 0, 0, 16'h0000, 1,   0, 16'h0000, 0, 0, 0, 1, 1, 0);
    // Invalid opcodes 111 and 110: DEAD with valid low, nothing stored.
    vecs[16] = mk(1, 7, 0, 16'h0000, 0,   0, 16'h0000, 0, 0, 0, 1, 1, 0);
    vecs[17] = mk(1, 0, 0, 16'hDEAD, 0,   0, 16'h0000, 0, 0, 0, 1, 1, 1);
    vecs[18] = mk(1, 6, 0, 16'hDEAD, 0,   0, 16'h0000, 0, 0, 0, 1, 1, 1);
    vecs[19] = mk(1, 0, 0, 16'hDEAD, 0,   0, 16'h0000, 0, 0, 0, 1, 1, 2);
    // Backpressure on 000C/tag 101 for three cycles, then mid-run reset.
    vecs[20] = mk(1, 5, 0, 16'h0000, 0,   0, 16'h0000, 0, 0, 0, 1, 1, 2);
    vecs[21] = mk(1, 0, 1, 16'h000C, 0,   1, 16'h000C, 5, 1, 0, 0, 1, 2);
    vecs[22] = mk(1, 0, 0, 16'h0000, 0,   1, 16'h000C, 5, 1, 0, 0, 1, 2);
    vecs[23] = mk(1, 0, 0, 16'h0000, 0,   1, 16'h000C, 5, 1, 0, 0, 1, 2);
    vecs[24] = mk(1, 0, 0, 16'h0000, 0,   1, 16'h000C, 5, 1, 0, 0, 1, 2);
    vecs[25] = mk(0, 0, 1, 16'h0077, 1,   0, 16'h0000, 0, 0, 0, 1, 0, 0);
    vecs[26] = mk(1, 0, 0, 16'h0000, 0,   0, 16'h0000, 0, 0, 0, 1, 0, 0);

    for (int i = 0; i < int'(NVec); i++) begin
      drive(vecs[i].rst, vecs[i].op, vecs[i].v, vecs[i].res, vecs[i].rdy);
      chk("out_valid", i, 32'(bus.out_valid), 32'(vecs[i].e_valid));
      chk("out_data",  i, 32'(bus.out_data),  32'(vecs[i].e_data));
      chk("out_tag",   i, 32'(bus.out_tag),   32'(vecs[i].e_tag));
      chk("count",     i, 32'(bus.count),     32'(vecs[i].e_count));
      chk("full",      i, 32'(bus.full),      32'(vecs[i].e_full));
      chk("empty",     i, 32'(bus.empty),     32'(vecs[i].e_empty));
      chk("drop_cnt",  i, 32'(bus.drop_cnt),  32'(vecs[i].e_drop));
      chk("err_cnt",   i, 32'(bus.err_cnt),   32'(vecs[i].e_err));
    end

    // drop_cnt saturates: 4 stored, 296 dropped.
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 3'd0, 1'b1, 16'(i + 1), 1'b0);
    end
    chk("drop_sat",      100, 32'(bus.drop_cnt), 32'd255);
    chk("drop_sat_cnt",  100, 32'(bus.count),    32'd4);
    chk("drop_sat_head", 100, 32'(bus.out_data), 32'd1);

    // err_cnt saturates with opcode 111 held and valid low.
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 3'd7, 1'b0, 16'hDEAD, 1'b0);
    end
    chk("err_sat",      101, 32'(bus.err_cnt),  32'd255);
    chk("err_sat_drop", 101, 32'(bus.drop_cnt), 32'd255);
    chk("err_sat_cnt",  101, 32'(bus.count),    32'd4);

    drive(1'b0, 3'd0, 1'b0, 16'h0000, 1'b0);
    chk("rst_count", 102, 32'(bus.count),    32'd0);
    chk("rst_drop",  102, 32'(bus.drop_cnt), 32'd0);
    chk("rst_err",   102, 32'(bus.err_cnt),  32'd0);

`ifdef ALU_RESULT_BUFFER_PARITY_EN
    drive(1'b1, 3'd0, 1'b1, 16'h0007, 1'b0);
    chk("out_par_7",  103, 32'(bus.out_par),  32'd1);
    drive(1'b1, 3'd0, 1'b1, 16'h0003, 1'b1);  // pops 0007, pushes 0003
    chk("par_head_3", 103, 32'(bus.out_data), 32'h0003);
    chk("out_par_3",  103, 32'(bus.out_par),  32'd0);
    chk("par_err_1",  103, 32'(bus.par_err),  32'd0);
    drive(1'b1, 3'd0, 1'b0, 16'h0000, 1'b1);
    chk("par_err_2",  103, 32'(bus.par_err),  32'd0);
    chk("out_par_mt", 103, 32'(bus.out_par),  32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
- Downstream stage of the 8-bit ALU.
- Captures each registered ALU result (result[15:0], valid) and tags it with the opcode that produced it.
- Holds results in a small FIFO and drains them to a consumer over a valid/ready handshake.
- Counts results dropped on overflow and invalid-opcode results (16'hDEAD) for debug.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2
- DATA_W, 16, result width; matches ALU result
- OP_W, 3, opcode/tag width; matches ALU opcode
- CNT_W, 8, width of the saturating drop/error counters

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous reset, active-low (rst==0 resets on the next rising clk)
- alu_opcode  in  OP_W  opcode driven into the ALU this cycle
- alu_valid  in  1  ALU valid output
- alu_result  in  DATA_W  ALU result output
- out_valid  out  1  head entry available
- out_ready  in  1  consumer accepts head entry
- out_data  out  DATA_W  head entry result
- out_tag  out  OP_W  head entry opcode
- count  out  $clog2(DEPTH+1)  occupancy, 0..DEPTH
- full  out  1  count==DEPTH
- empty  out  1  count==0
- drop_cnt  out  CNT_W  valid results lost because the FIFO was full
- err_cnt  out  CNT_W  invalid-opcode results observed

Behaviour:
- Tag alignment:
  - The ALU result lags its opcode by one cycle.
  - op_d is a register capturing alu_opcode every cycle.
  - The tag for the alu_result/alu_valid pair sampled at cycle N is op_d, i.e. alu_opcode at N-1.
- Reset (rst==0 at a rising edge):
  - wr_ptr=rd_ptr=0, count=0, op_d=0, drop_cnt=0, err_cnt=0.
  - Outputs: empty=1, full=0, out_valid=0, out_data=0, out_tag=0.
  - Reset mid-operation discards all stored entries. No push, pop or counting happens in a reset cycle.
- Push condition: push = alu_valid && (!full || pop).
  - Writes {op_d, alu_result} at wr_ptr. wr_ptr wraps DEPTH-1 -> 0.
- Pop condition: pop = out_valid && out_ready.
  - Advances rd_ptr, with the same wrap.
- Head presentation: first-word-fall-through.
  - out_valid = !empty; out_data/out_tag = entry at rd_ptr.
  - When empty, out_data=0 and out_tag=0.
  - No bypass: an entry pushed at edge N is visible from edge N onward (first cycle out_valid=1 is N+1 in cycle terms).
- count update:
  - push only: +1
  - pop only: -1
  - both, or neither: unchanged
- Full and pop in the same cycle: the push is accepted and count stays DEPTH.
- Full with no pop: an incoming alu_valid is dropped and drop_cnt increments.
- Empty with push: count -> 1. The pop is ignored because out_valid=0.
- Invalid result: when alu_valid==0 && op_d > 3'b101, err_cnt increments.
  - Nothing is written; the ALU presents 16'hDEAD with valid low.
- alu_valid==0 with a legal op_d: no action.
- Counters saturate at all-ones and never wrap.
- Handshake rule: out_data/out_tag stay stable while out_valid && !out_ready.

Optional Feature:
- Macro: ALU_RESULT_BUFFER_PARITY_EN.
- When defined:
  - Each entry also stores an even-parity bit, ^alu_result computed at write time.
  - Extra port out_par (out, 1), giving the head entry's stored parity; 0 when empty.
  - Extra port par_err (out, 1), registered; asserted for one cycle after a pop where ^out_data != out_par.
- When not defined: neither port exists and no parity storage is built.

Test Plan:
- Reset + single result:
  - Stimulus: rst=0 for 2 cycles, then rst=1. Opcode 000 with a=10, b=15; alu_result=25 with alu_valid=1 one cycle later; out_ready=1.
  - Required: out_valid=1 with out_data=16'd25, out_tag=3'b000; empty=1 after the pop.
- Fill and overflow:
  - Stimulus: out_ready=0; 5 consecutive valid results 1..5 with DEPTH=4.
  - Required: full=1 and count=4 after 4; drop_cnt=1. Draining yields 1,2,3,4 in order.
- Simultaneous push/pop at full:
  - Stimulus: FIFO full, one cycle with alu_valid=1 (result 16'h00AA) and out_ready=1.
  - Required: count stays 4, drop_cnt unchanged, 16'h00AA is last out.
- Invalid opcode:
  - Stimulus: opcode 3'b111; next cycle alu_valid=0, alu_result=16'hDEAD.
  - Required: err_cnt=1, count unchanged, 16'hDEAD never appears on out_data.
- Backpressure stability and reset mid-operation:
  - Stimulus: out_ready=0 for 3 cycles holding entry 16'h000C with tag 101; then rst=0 for one cycle.
  - Required: out_data/out_tag held for all 3 cycles; after reset count=0, out_valid=0, counters=0.
- Parity (ALU_RESULT_BUFFER_PARITY_EN defined):
  - Stimulus: push 16'h0007.
  - Required: out_par=1, par_err stays 0 on pop.
